// File: rtl/spi_adc_responder.sv
// SPI ADC responder: emulates a 12-bit serial ADC output stage (null bit,
// MSB-first word, LSB-first repeat, zero tail), driven from an external SCK/CS
// that is oversampled in the clk domain.
module spi_adc_responder #(
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT_OUT  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck_in,
  input  logic        cs_n_in,
  input  logic [11:0] sample_data,
  output logic        miso,
  output logic        miso_oe,
  output logic        busy,
  output logic        frame_done,
  output logic        short_frame
);

  typedef enum logic [2:0] {
    IDLE, SAMPLE, NULL_BIT, DATA_MSB, DATA_LSB, TAIL, WAIT_CS_HIGH
  } state_t;

  localparam logic [2:0] FLUSH_N = 3'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sckSync, csSync;
  logic                   sckHist, csHist;
  logic                   sckNow, csNow, sckFall, csFall, csRise;
  logic [2:0]             flushCnt;
  logic                   flushDone;

  state_t      state, stateNext;
  logic [4:0]  f, fNext, fInc;
  logic [11:0] shadow, shadowNext;
  logic        misoNext, oeNext, busyNext, doneNext, shortNext;
  logic [3:0]  msbIdx, lsbIdx;

  assign sckNow  = sckSync[SYNC_STAGES-1];
  assign csNow   = csSync[SYNC_STAGES-1];
  assign sckFall = sckHist & ~sckNow;
  assign csFall  = csHist & ~csNow;
  assign csRise  = ~csHist & csNow;

  // Synchronizers plus one history flop each; reset to the idle-high level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sckSync <= '1;
      csSync  <= '1;
      sckHist <= 1'b1;
      csHist  <= 1'b1;
    end else begin
      sckSync <= {sckSync[SYNC_STAGES-2:0], sck_in};
      csSync  <= {csSync[SYNC_STAGES-2:0], cs_n_in};
      sckHist <= sckNow;
      csHist  <= csNow;
    end
  end

  // After reset the synchronizers hold a forced 1; wait until the real pin
  // level has propagated before trusting cs_n as "high".
  always_ff @(posedge clk) begin
    if (reset)           flushCnt <= '0;
    else if (!flushDone) flushCnt <= flushCnt + 3'd1;
  end
  assign flushDone = (flushCnt >= FLUSH_N);

  // State, counter, shadow word and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_CS_HIGH;
      f           <= '0;
      shadow      <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      state       <= stateNext;
      f           <= fNext;
      shadow      <= shadowNext;
      miso        <= misoNext;
      miso_oe     <= oeNext;
      busy        <= busyNext;
      frame_done  <= doneNext;
      short_frame <= shortNext;
    end
  end

  assign fInc   = (f == 5'd31) ? f : f + 5'd1;
  assign msbIdx = 4'(5'd13 - fInc);
  assign lsbIdx = 4'(fInc - 5'd13);

  // Next-state and output decode; a CS rise always pre-empts an SCK fall.
  always_comb begin
    stateNext  = state;
    fNext      = f;
    shadowNext = shadow;
    misoNext   = miso;
    oeNext     = miso_oe;
    busyNext   = busy;
    doneNext   = 1'b0;
    shortNext  = 1'b0;
    case (state)
      WAIT_CS_HIGH: begin
        if (flushDone && csNow) stateNext = IDLE;
      end
      IDLE: begin
        if (csFall) begin
          shadowNext = sample_data;
          fNext      = '0;
          busyNext   = 1'b1;
          oeNext     = 1'b1;
          misoNext   = 1'b0;
          stateNext  = SAMPLE;
        end
      end
      default: begin
        if (csRise) begin
          oeNext    = 1'b0;
          misoNext  = 1'b0;
          busyNext  = 1'b0;
          stateNext = IDLE;
          if (f >= 5'd13) doneNext  = 1'b1;
          else            shortNext = 1'b1;
        end else if (sckFall) begin
          fNext = fInc;
          case (state)
            SAMPLE: begin
              misoNext  = 1'b0;
              stateNext = NULL_BIT;
            end
            NULL_BIT, DATA_MSB: begin
              misoNext = shadow[msbIdx] ^ INVERT_OUT;
              if (fInc >= 5'd13) stateNext = DATA_LSB;
              else               stateNext = DATA_MSB;
            end
            DATA_LSB: begin
              misoNext = shadow[lsbIdx] ^ INVERT_OUT;
              if (fInc >= 5'd24) stateNext = TAIL;
            end
            default: misoNext = 1'b0;
          endcase
        end
      end
    endcase
  end

endmodule
